// File: rtl/coin_start_sequencer.sv
// coin_start_sequencer
//
// Turns player start requests into a timed coin-then-start pulse sequence
// for the core's coin and start inputs. One coin line is shared by both
// players. Each player has a one-deep pending flag, and P1 has fixed
// priority when both are waiting.
//
// Sequence: IDLE -> COIN -> GAP -> START -> HOLD -> IDLE.
//
// Optional feature, selected by the macro COIN_DOUBLE_EN:
//   When defined, a P2-owned sequence issues two coin pulses,
//   COIN -> GAP -> COIN -> GAP -> START, so that the second credit is paid
//   for. P1-owned sequences are unchanged. When undefined, every sequence
//   issues a single coin pulse and the coin-count register is not built.
//
// Single clock domain (clk_sys). RESET_N is asynchronous and active-low.

module coin_start_sequencer #(
    parameter int unsigned COIN_CYCLES  = 1200000,
    parameter int unsigned GAP_CYCLES   = 600000,
    parameter int unsigned START_CYCLES = 1200000,
    parameter int unsigned HOLD_CYCLES  = 2400000
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic start1_req,
    input  logic start2_req,
    output logic coin,
    output logic start1,
    output logic start2,
    output logic busy
);

    // ------------------------------------------------------------------
    // Duration counter sizing
    // ------------------------------------------------------------------
    localparam int unsigned MaxCg     = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxSh     = (START_CYCLES > HOLD_CYCLES) ? START_CYCLES : HOLD_CYCLES;
    localparam int unsigned MaxCycles = (MaxCg > MaxSh) ? MaxCg : MaxSh;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    typedef logic [CntW-1:0] cnt_t;

    // Each state is loaded with N-1 on entry and exits when the count is 0.
    localparam cnt_t CoinLoad  = cnt_t'(COIN_CYCLES - 1);
    localparam cnt_t GapLoad   = cnt_t'(GAP_CYCLES - 1);
    localparam cnt_t StartLoad = cnt_t'(START_CYCLES - 1);
    localparam cnt_t HoldLoad  = cnt_t'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCoin,
        StGap,
        StStart,
        StHold
    } state_e;

    typedef enum logic {
        OwnP1,
        OwnP2
    } owner_e;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic   req1_dly_q;
    logic   req2_dly_q;
    logic   rise1;
    logic   rise2;

    logic   p1_pend_q;
    logic   p1_pend_d;
    logic   p2_pend_q;
    logic   p2_pend_d;
    logic   take1;
    logic   take2;

    state_e state_q;
    state_e state_d;
    cnt_t   cnt_q;
    cnt_t   cnt_d;
    logic   cnt_done;
    owner_e owner_q;
    owner_e owner_d;

    logic   coin_q;
    logic   start1_q;
    logic   start2_q;
    logic   busy_q;

`ifdef COIN_DOUBLE_EN
    // Set once the first of the two P2 coin pulses has been issued.
    logic   coin_cnt_q;
    logic   coin_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Request edge detection
    // ------------------------------------------------------------------

    // Delay each request by one cycle so that a held level yields one rise.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            req1_dly_q <= 1'b0;
            req2_dly_q <= 1'b0;
        end else begin
            req1_dly_q <= start1_req;
            req2_dly_q <= start2_req;
        end
    end

    assign rise1 = start1_req & ~req1_dly_q;
    assign rise2 = start2_req & ~req2_dly_q;

    // ------------------------------------------------------------------
    // Pending flags
    // ------------------------------------------------------------------

    // IDLE consumes the highest-priority pending request.
    assign take1 = (state_q == StIdle) && p1_pend_q;
    assign take2 = (state_q == StIdle) && !p1_pend_q && p2_pend_q;

    // One-deep flags; a rise in the cycle the flag is consumed re-arms it.
    always_comb begin
        p1_pend_d = p1_pend_q;
        p2_pend_d = p2_pend_q;
        if (take1) begin
            p1_pend_d = 1'b0;
        end
        if (take2) begin
            p2_pend_d = 1'b0;
        end
        if (rise1) begin
            p1_pend_d = 1'b1;
        end
        if (rise2) begin
            p2_pend_d = 1'b1;
        end
    end

    // Hold the pending flags.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            p1_pend_q <= 1'b0;
            p2_pend_q <= 1'b0;
        end else begin
            p1_pend_q <= p1_pend_d;
            p2_pend_q <= p2_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    assign cnt_done = (cnt_q == '0);

    // Choose the next state, duration count and owner.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
`ifdef COIN_DOUBLE_EN
        coin_cnt_d = coin_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef COIN_DOUBLE_EN
                coin_cnt_d = 1'b0;
`endif
                cnt_d = '0;
                if (take1) begin
                    state_d = StCoin;
                    cnt_d   = CoinLoad;
                    owner_d = OwnP1;
                end else if (take2) begin
                    state_d = StCoin;
                    cnt_d   = CoinLoad;
                    owner_d = OwnP2;
                end
            end

            StCoin: begin
                if (cnt_done) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            StGap: begin
                if (cnt_done) begin
`ifdef COIN_DOUBLE_EN
                    // P2 buys its second credit before the start pulse.
                    if ((owner_q == OwnP2) && !coin_cnt_q) begin
                        state_d    = StCoin;
                        cnt_d      = CoinLoad;
                        coin_cnt_d = 1'b1;
                    end else begin
                        state_d = StStart;
                        cnt_d   = StartLoad;
                    end
`else
                    state_d = StStart;
                    cnt_d   = StartLoad;
`endif
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            StStart: begin
                if (cnt_done) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            StHold: begin
                if (cnt_done) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------

    // Outputs are decoded from the next state so that they line up with it.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            owner_q  <= OwnP1;
            coin_q   <= 1'b0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            coin_q   <= (state_d == StCoin);
            start1_q <= (state_d == StStart) && (owner_d == OwnP1);
            start2_q <= (state_d == StStart) && (owner_d == OwnP2);
            busy_q   <= (state_d != StIdle);
        end
    end

`ifdef COIN_DOUBLE_EN
    // Track how many coin pulses the current P2 sequence has issued.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            coin_cnt_q <= 1'b0;
        end else begin
            coin_cnt_q <= coin_cnt_d;
        end
    end
`endif

    assign coin   = coin_q;
    assign start1 = start1_q;
    assign start2 = start2_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Directed bench for coin_start_sequencer with COIN=4, GAP=3, START=5, HOLD=2.
// Edge numbers count rising clock edges from the start of each scenario;
// RESET_N is released after edge 3. Expected windows are hand-computed and
// depend on whether COIN_DOUBLE_EN is defined.

module tb_coin_start_sequencer;

`ifdef COIN_DOUBLE_EN
    localparam bit DoubleEn = 1'b1;
`else
    localparam bit DoubleEn = 1'b0;
`endif

    logic clk_sys;
    logic RESET_N;
    logic start1_req;
    logic start2_req;
    logic coin;
    logic start1;
    logic start2;
    logic busy;

    int checks;
    int failures;
    int ecnt;

    coin_start_sequencer #(
        .COIN_CYCLES (4),
        .GAP_CYCLES  (3),
        .START_CYCLES(5),
        .HOLD_CYCLES (2)
    ) dut (
        .clk_sys   (clk_sys),
        .RESET_N   (RESET_N),
        .start1_req(start1_req),
        .start2_req(start2_req),
        .coin      (coin),
        .start1    (start1),
        .start2    (start2),
        .busy      (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_sys);
        ecnt = ecnt + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, ecnt, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic ec, input logic es1, input logic es2,
                        input logic eb);
        chk({tag, ".coin"}, coin, ec);
        chk({tag, ".start1"}, start1, es1);
        chk({tag, ".start2"}, start2, es2);
        chk({tag, ".busy"}, busy, eb);
    endtask

    function automatic logic win(input int e, input int lo, input int hi);
        return (e >= lo) && (e <= hi);
    endfunction

    // Assert reset, restart edge numbering, release after edge 3.
    task automatic begin_scenario();
        RESET_N    = 1'b0;
        start1_req = 1'b0;
        start2_req = 1'b0;
        ecnt       = 0;
        repeat (3) tick();
        RESET_N = 1'b1;
    endtask

    initial begin
        int  n_coin;
        int  n_s1;
        int  n_s2;
        logic prev_coin;
        logic prev_s1;
        logic prev_s2;

        checks     = 0;
        failures   = 0;
        ecnt       = 0;
        RESET_N    = 1'b0;
        start1_req = 1'b0;
        start2_req = 1'b0;

        // Reset state: everything low while held in reset.
        tick();
        chk4("reset_state", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single P1 request rising at edge 10.
        begin_scenario();
        for (int i = 0; i < 26; i++) begin
            tick();
            if (ecnt == 9)  start1_req = 1'b1;
            if (ecnt == 12) start1_req = 0;
            chk4("single_p1", win(ecnt, 11, 14), win(ecnt, 18, 22), 1'b0, win(ecnt, 11, 24));
        end

        // Both requests rise at edge 10: P1 first, P2 queued.
        begin_scenario();
        for (int i = 0; i < 47; i++) begin
            tick();
            if (ecnt == 9) begin
                start1_req = 1'b1;
                start2_req = 1'b1;
            end
            if (ecnt == 12) begin
                start1_req = 1'b0;
                start2_req = 1'b0;
            end
            if (DoubleEn) begin
                chk4("simul_dbl", win(ecnt, 11, 14) | win(ecnt, 26, 29) | win(ecnt, 33, 36),
                     win(ecnt, 18, 22), win(ecnt, 40, 44),
                     win(ecnt, 11, 24) | win(ecnt, 26, 46));
            end else begin
                chk4("simul", win(ecnt, 11, 14) | win(ecnt, 26, 29), win(ecnt, 18, 22),
                     win(ecnt, 33, 37), win(ecnt, 11, 24) | win(ecnt, 26, 39));
            end
        end

        // P2 alone rising at edge 10.
        begin_scenario();
        for (int i = 0; i < 37; i++) begin
            tick();
            if (ecnt == 9)  start2_req = 1'b1;
            if (ecnt == 12) start2_req = 1'b0;
            if (DoubleEn) begin
                chk4("p2_dbl", win(ecnt, 11, 14) | win(ecnt, 18, 21), 1'b0,
                     win(ecnt, 25, 29), win(ecnt, 11, 31));
            end else begin
                chk4("p2_single", win(ecnt, 11, 14), 1'b0, win(ecnt, 18, 22),
                     win(ecnt, 11, 24));
            end
        end

        // Re-request at edge 16 while busy: second P1 sequence queued.
        begin_scenario();
        for (int i = 0; i < 42; i++) begin
            tick();
            if (ecnt == 9)  start1_req = 1'b1;
            if (ecnt == 12) start1_req = 1'b0;
            if (ecnt == 15) start1_req = 1'b1;
            if (ecnt == 18) start1_req = 1'b0;
            chk4("rereq", win(ecnt, 11, 14) | win(ecnt, 26, 29),
                 win(ecnt, 18, 22) | win(ecnt, 33, 37), 1'b0,
                 win(ecnt, 11, 24) | win(ecnt, 26, 39));
        end

        // Reset asserted at edge 20, in the middle of START.
        begin_scenario();
        for (int i = 0; i < 17; i++) begin
            tick();
            if (ecnt == 9)  start1_req = 1'b1;
            if (ecnt == 12) start1_req = 1'b0;
            chk4("pre_rst", win(ecnt, 11, 14), win(ecnt, 18, 22), 1'b0, win(ecnt, 11, 24));
        end
        RESET_N = 1'b0;
        #1;
        chk4("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        RESET_N = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk4("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Held level for 100 cycles: one coin pulse and one start1 pulse.
        begin_scenario();
        n_coin    = 0;
        n_s1      = 0;
        n_s2      = 0;
        prev_coin = 1'b0;
        prev_s1   = 1'b0;
        prev_s2   = 1'b0;
        for (int i = 0; i < 137; i++) begin
            tick();
            if (ecnt == 9)   start1_req = 1'b1;
            if (ecnt == 109) start1_req = 1'b0;
            if (coin && !prev_coin) n_coin++;
            if (start1 && !prev_s1) n_s1++;
            if (start2 && !prev_s2) n_s2++;
            prev_coin = coin;
            prev_s1   = start1;
            prev_s2   = start2;
        end
        chk_int("held_coin_pulses", n_coin, 1);
        chk_int("held_start1_pulses", n_s1, 1);
        chk_int("held_start2_pulses", n_s2, 0);
        chk("held_busy_end", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
